// File: rtl/apb_pkg.sv
// Shared types and default sizes for the APB register-memory completer.
// No logic; nothing here has latency.
// No handshaking; this file only supplies types and constants.
package apb_pkg;

  // Bus-side protocol state of the completer
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int ADDR_WIDTH_D = 32;
  localparam int DATA_WIDTH_D = 32;
  localparam int MEM_DEPTH_D  = 32;

  // Wait-state counter width, enough for 0..15 wait cycles
  localparam int WCNT_W = 4;

endpackage

// File: rtl/apb_mem_array.sv
// Word memory: one synchronous write port and one combinational read port.
// Write commits on the clock edge; read data is valid in the same cycle.
// No backpressure; the caller owns all sequencing.
module apb_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 32,
  parameter int IDX_W      = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // Clear every word on reset; otherwise accept one write per cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Callers only present in-range indices here
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer in front of a small word-addressed register memory.
// Two cycles per transfer (setup + access), plus WAIT_STATES access cycles.
// Stalls the requester by holding Pready low during the configured wait cycles.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_D,
  parameter int DATA_WIDTH  = DATA_WIDTH_D,
  parameter int MEM_DEPTH   = MEM_DEPTH_D,
  parameter int WAIT_STATES = 0
) (
  input  logic                  Pclk,
  input  logic                  Prst,
  input  logic                  Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [ADDR_WIDTH-1:0] Paddr,
  input  logic [DATA_WIDTH-1:0] Pwdata,
  output logic                  Pready,
  output logic                  Pslverr,
  output logic [DATA_WIDTH-1:0] Prdata
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // Depth widened by one bit so the range compare cannot truncate
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [WCNT_W-1:0]   WS      = WCNT_W'(WAIT_STATES);

  apb_state_e            state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic                  in_range;
  logic                  setup;
  logic                  ready;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign in_range = ({1'b0, Paddr} < DEPTH_X);
  // A setup phase is recognised in either state; in ACCESS it restarts the transfer
  assign setup    = Pselx & ~Penable;
  assign ready    = (state_q == ACCESS) & Pselx & Penable & (wcnt_q == WS);

  assign Pready  = ready;
  assign Pslverr = ready & err_q;
  assign Prdata  = prdata_q;

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk_i   (Pclk),
    .rst_ni  (Prst),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (Pwdata),
    .raddr_i (Paddr[IDX_W-1:0]),
    .rdata_o (mem_rdata)
  );

  // Next-state, transfer latching and memory write strobe
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    idx_d    = idx_q;
    write_d  = write_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    mem_we   = 1'b0;

    if (setup) begin
      state_d = ACCESS;
      wcnt_d  = '0;
      idx_d   = Paddr[IDX_W-1:0];
      write_d = Pwrite;
      err_d   = ~in_range;
      // Read data is captured at setup so later Paddr changes cannot disturb it
      if (!Pwrite) begin
        prdata_d = in_range ? mem_rdata : '0;
      end
    end else begin
      case (state_q)
        ACCESS: begin
          if (!Pselx) begin
            state_d = IDLE;
          end else if (ready) begin
            mem_we  = write_q & ~err_q;
            state_d = IDLE;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        default: begin
          // Penable without a preceding setup is ignored
          state_d = IDLE;
        end
      endcase
    end
  end

  // Protocol state and latched transfer attributes
  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem with zero and two wait states.
// Expected responses are queued at setup and retired when Pready is seen.
// Requester-side waits are bounded so a stuck Pready still reaches the summary.
module tb_apb_slave_mem;

  logic        Pclk = 1'b0;
  logic        Prst;
  logic        Psel0, Psel2, Penable, Pwrite;
  logic [31:0] Paddr, Pwdata;
  logic        Pready0, Pslverr0, Pready2, Pslverr2;
  logic [31:0] Prdata0, Prdata2;

  always #5 Pclk = ~Pclk;

  apb_slave_mem #(.WAIT_STATES(0)) dut0 (
    .Pclk(Pclk), .Prst(Prst), .Pselx(Psel0), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Pready(Pready0), .Pslverr(Pslverr0), .Prdata(Prdata0)
  );

  apb_slave_mem #(.WAIT_STATES(2)) dut2 (
    .Pclk(Pclk), .Prst(Prst), .Pselx(Psel2), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Pready(Pready2), .Pslverr(Pslverr2), .Prdata(Prdata2)
  );

  typedef struct {
    bit          is_rd;
    bit          err;
    logic [31:0] rd;
    int          waits;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model0 [32];
  logic [31:0] model2 [32];
  logic [31:0] last_rd0, last_rd2;
  int          vectors     = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit use2);
    return use2 ? Pready2 : Pready0;
  endfunction

  function automatic logic serr(input bit use2);
    return use2 ? Pslverr2 : Pslverr0;
  endfunction

  function automatic logic [31:0] rdat(input bit use2);
    return use2 ? Prdata2 : Prdata0;
  endfunction

  // One complete transfer; Paddr is scrambled in the access phase to prove latching
  task automatic xfer(input bit use2, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   waits;
    logic r;
    logic er;
    e.is_rd = !wr;
    e.err   = (addr >= 32);
    e.waits = use2 ? 2 : 0;
    e.rd    = e.err ? 32'd0 : (use2 ? model2[addr[4:0]] : model0[addr[4:0]]);

    @(negedge Pclk);
    Psel0 = !use2; Psel2 = use2; Penable = 1'b0;
    Pwrite = wr; Paddr = addr; Pwdata = data;
    exp_q.push_back(e);

    @(negedge Pclk);
    Penable = 1'b1;
    Paddr   = ~addr;
    waits   = 0;
    #1 r = rdy(use2);
    while (!r && waits < 20) begin
      @(negedge Pclk);
      waits++;
      #1 r = rdy(use2);
    end
    er = serr(use2);
    e  = exp_q.pop_front();
    check("ready", {31'd0, r}, 32'd1);
    check("wait_cycles", waits, e.waits);
    check("slverr", {31'd0, er}, {31'd0, e.err});

    @(negedge Pclk);
    Psel0 = 1'b0; Psel2 = 1'b0; Penable = 1'b0;
    #1;
    check("ready_after", {31'd0, rdy(use2)}, 32'd0);
    if (e.is_rd) begin
      if (use2) last_rd2 = e.rd; else last_rd0 = e.rd;
    end
    check(e.is_rd ? "prdata_read" : "prdata_hold", rdat(use2), use2 ? last_rd2 : last_rd0);
    if (wr && !e.err) begin
      if (use2) model2[addr[4:0]] = data; else model0[addr[4:0]] = data;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      model0[i] = '0;
      model2[i] = '0;
    end
    last_rd0 = '0; last_rd2 = '0;
    Psel0 = 1'b0; Psel2 = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = '0; Pwdata = '0;

    Prst = 1'b0;
    #10;
    check("rst_ready0", {31'd0, Pready0}, 32'd0);
    check("rst_slverr0", {31'd0, Pslverr0}, 32'd0);
    check("rst_prdata0", Prdata0, 32'd0);
    check("rst_ready2", {31'd0, Pready2}, 32'd0);
    check("rst_prdata2", Prdata2, 32'd0);
    Prst = 1'b1;

    xfer(0, 0, 0, 0);

    // Penable without a setup phase must not start a transfer
    @(negedge Pclk);
    Psel0 = 1'b1; Penable = 1'b1; Paddr = 32'd1;
    #1 check("no_setup_ready", {31'd0, Pready0}, 32'd0);
    @(negedge Pclk);
    #1 check("no_setup_ready2", {31'd0, Pready0}, 32'd0);
    Psel0 = 1'b0; Penable = 1'b0;

    xfer(0, 1, 1, 32'd7);
    xfer(0, 1, 2, 32'd3);
    xfer(0, 0, 0, 0);
    xfer(0, 0, 1, 0);
    xfer(0, 0, 2, 0);

    xfer(0, 1, 40, 32'hDEAD);
    xfer(0, 0, 40, 0);
    xfer(0, 0, 8, 0);
    xfer(0, 0, 1, 0);

    xfer(1, 1, 3, 32'd5);
    xfer(1, 0, 3, 0);

    // Abort: setup a write, then drop select before the access phase
    @(negedge Pclk);
    Psel0 = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'd4; Pwdata = 32'd9;
    @(negedge Pclk);
    Psel0 = 1'b0;
    #1 check("abort_ready", {31'd0, Pready0}, 32'd0);
    xfer(0, 0, 4, 0);

    xfer(0, 1, 5, 32'h1234_5678);
    xfer(0, 0, 5, 0);

    check("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB3 completer (slave) fronting a small word-addressed register memory.
- Sits on the peripheral bus behind the bridge.
- Accepts single read/write transfers using the SETUP/ACCESS handshake.
- Supports optional wait states; reports out-of-range addresses via Pslverr.

Parameters:
- ADDR_WIDTH, 32, width of Paddr.
- DATA_WIDTH, 32, width of Pwdata/Prdata and of each memory word.
- MEM_DEPTH, 32, number of memory words; valid word addresses are 0..MEM_DEPTH-1.
- WAIT_STATES, 0, number of ACCESS cycles with Pready low before completion (0..15).

Ports:
- Pclk  in  1  bus clock; all state changes on the rising edge.
- Prst  in  1  reset, asynchronous, active-low (Prst=0 resets).
- Pselx  in  1  slave select.
- Penable  in  1  access-phase strobe.
- Pwrite  in  1  1=write, 0=read.
- Paddr  in  ADDR_WIDTH  word address (not byte address); transfer N uses index Paddr directly.
- Pwdata  in  DATA_WIDTH  write data.
- Pready  out  1  transfer completes on the edge where Pready=1.
- Pslverr  out  1  error response, valid only while Pready=1.
- Prdata  out  DATA_WIDTH  read data.

Behaviour:
- Reset (Prst low, asynchronous):
  - State=IDLE; wait counter=0; latched addr/dir=0.
  - Pready=0, Pslverr=0, Prdata=0.
  - All memory words cleared to 0.
- FSM states: IDLE, ACCESS.
  - IDLE->ACCESS on an edge sampling Pselx=1, Penable=0 (setup phase).
  - That edge latches Paddr and Pwrite, clears the wait counter, and sets addr_err = (Paddr >= MEM_DEPTH).
  - For a read at that edge, Prdata is loaded with mem[Paddr], or 0 if addr_err.
  - IDLE with Penable=1 but no prior setup is ignored: stay IDLE, no side effects.
- ACCESS:
  - Pready = Pselx & Penable & (wcnt == WAIT_STATES). Combinational; 0 in IDLE.
  - Edge with Pselx & Penable & !Pready: wcnt++ and stay in ACCESS.
  - Edge with Pselx & Penable & Pready (completion): for a write with !addr_err, mem[latched addr] <= Pwdata sampled at that edge. Then go to IDLE.
  - Edge with Pselx=0 (abort): go to IDLE; no memory write.
  - Edge with Pselx=1, Penable=0: stay in ACCESS (extended setup); re-latch addr/dir.
- Paddr/Pwrite changes after the setup edge are ignored; the latched values are used.
- Pslverr = Pready & addr_err.
- Error transfers never modify memory and return Prdata=0.
- Prdata holds its value until the next read setup edge. Writes do not change Prdata.
- Latency with WAIT_STATES=0: setup cycle plus one access cycle, so 2 Pclk per transfer. Back-to-back transfers re-enter through IDLE with a new setup.
- Read of an address written in the immediately preceding transfer returns the new data.
- Reset asserted mid-transfer: abort immediately; no write commits.

Decomposition:
- Shared package apb_pkg holds:
  - state enum (IDLE, ACCESS);
  - default widths ADDR_WIDTH_D=32, DATA_WIDTH_D=32;
  - MEM_DEPTH_D=32.
- One sub-module is natural: apb_mem_array.
  - Clears asynchronously on reset.
  - One synchronous write port.
  - One combinational read port feeding the Prdata register.
- FSM, wait counter and response logic stay in the top.

Test Plan:
- Reset: drive Prst=0 for 10 ns, then release. Pready=0, Pslverr=0, Prdata=0; a read of addr 0 returns 0.
- Writes: write Pwdata=7 to addr 1, then 3 to addr 2 (2-cycle transfers). Pready=1 in each access cycle, Pslverr=0.
- Reads: read addr 0, 1, 2 back-to-back, changing Paddr on the access edge. Prdata = 0, 7, 3 respectively, stable after each transfer.
- Out of range: write 0xDEAD to addr 40, then read addr 40. Pslverr=1 with Pready both times; read returns 0; no memory word changes.
- Wait states (WAIT_STATES=2): write 5 to addr 3. Pready low for 2 access cycles, high on the 3rd; a read of addr 3 returns 5.
- Abort: setup a write of 9 to addr 4, drop Pselx before Penable. No write occurs; a read of addr 4 returns 0.
